train_plant_model: RTL and testbench

Behavioural-synthesizable model of the two-train layout that the track controller FSM drives. It consumes the controller's switch commands (sw1, sw2, sw3) and track-power commands (ta0, ta1, tb0, tb1), moves train A and train B around a discretised loop, and produces the position sensors s1..s5 the controller reads back. It sits opposite the controller in the closed-loop FPGA test harness, replacing the physical layout. It also flags collisions and illegal power commands.

---
 rtl/train_plant_model_if.sv | 23 ++
 rtl/train_plant_model.sv | 158 +++++++++++++++
 tb/tb_train_plant_model.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/train_plant_model_if.sv
// Controller <-> plant signal bundle: switch/power commands toward the plant,
// sensors, sticky flags and debug positions back toward the controller.
interface train_plant_model_if #(
    parameter int PW = 6
);
    // Every signal is a plain level sampled on each clk edge; there is no valid/ready handshake.
    logic          sw1, sw2, sw3;
    logic          ta0, ta1, tb0, tb1;
    logic          s1, s2, s3, s4, s5;
    logic          collision;
    logic          fault;
    logic [PW-1:0] posa, posb;

    modport master (
        output sw1, sw2, sw3, ta0, ta1, tb0, tb1,
        input  s1, s2, s3, s4, s5, collision, fault, posa, posb
    );

    modport slave (
        input  sw1, sw2, sw3, ta0, ta1, tb0, tb1,
        output s1, s2, s3, s4, s5, collision, fault, posa, posb
    );
endinterface

// File: rtl/train_plant_model.sv
// Two-train discretised loop layout: moves trains under power commands,
// tracks the train A siding, and produces registered position sensors.
module train_plant_model #(
    parameter int LOOP_LEN  = 64,
    parameter int STEP_DIV  = 1000,
    parameter int P_S1      = 0,
    parameter int P_S2      = 32,
    parameter int P_S3      = 16,
    parameter int P_S4      = 48,
    parameter int P_BRANCH  = 22,
    parameter int P_S5      = 24,
    parameter int P_MERGE   = 28,
    parameter int SHARED_LO = 12,
    parameter int SHARED_HI = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    train_plant_model_if.slave   bus
);
    localparam int PW = $clog2(LOOP_LEN);

    localparam logic [PW-1:0] POS_S1     = PW'(P_S1);
    localparam logic [PW-1:0] POS_S2     = PW'(P_S2);
    localparam logic [PW-1:0] POS_S3     = PW'(P_S3);
    localparam logic [PW-1:0] POS_S4     = PW'(P_S4);
    localparam logic [PW-1:0] POS_S5     = PW'(P_S5);
    localparam logic [PW-1:0] POS_BRANCH = PW'(P_BRANCH);
    localparam logic [PW-1:0] POS_BR_M1  = PW'(P_BRANCH - 1);
    localparam logic [PW-1:0] POS_MERGE  = PW'(P_MERGE);
    localparam logic [PW-1:0] POS_LO     = PW'(SHARED_LO);
    localparam logic [PW-1:0] POS_HI     = PW'(SHARED_HI);
    localparam logic [PW-1:0] POS_LAST   = PW'(LOOP_LEN - 1);
    localparam logic [15:0]   STEP_LAST  = 16'(STEP_DIV - 1);

    function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] p);
        return (p == POS_LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] pos_dec(input logic [PW-1:0] p);
        return (p == '0) ? POS_LAST : p - PW'(1);
    endfunction

    function automatic logic in_shared(input logic [PW-1:0] p);
        return (p >= POS_LO) && (p <= POS_HI);
    endfunction

    logic [PW-1:0] posa_q, posa_d, posb_q, posb_d;
    logic [15:0]   presc_a_q, presc_a_d, presc_b_q, presc_b_d;
    logic          in_siding_q, in_siding_d;
    logic          collision_q, collision_d;
    logic          fault_q, fault_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;

    logic fwd_a, rev_a, fwd_b, rev_b;
    logic step_a, step_b;
    logic unused_sw;

    // sw1/sw2 are reserved for crossover routing and intentionally ignored.
    assign unused_sw = bus.sw1 ^ bus.sw2;

    // 11 decodes as stopped for that train only; fault flags it separately.
    assign fwd_a = bus.ta0 & ~bus.ta1;
    assign rev_a = bus.ta1 & ~bus.ta0;
    assign fwd_b = bus.tb0 & ~bus.tb1;
    assign rev_b = bus.tb1 & ~bus.tb0;

    always_comb begin
        presc_a_d = presc_a_q;
        presc_b_d = presc_b_q;
        step_a    = 1'b0;
        step_b    = 1'b0;
        if (!collision_q) begin
            if (!(fwd_a | rev_a)) begin
                presc_a_d = '0;
            end else if (presc_a_q == STEP_LAST) begin
                presc_a_d = '0;
                step_a    = 1'b1;
            end else begin
                presc_a_d = presc_a_q + 16'd1;
            end
            if (!(fwd_b | rev_b)) begin
                presc_b_d = '0;
            end else if (presc_b_q == STEP_LAST) begin
                presc_b_d = '0;
                step_b    = 1'b1;
            end else begin
                presc_b_d = presc_b_q + 16'd1;
            end
        end
    end

    always_comb begin
        posa_d = posa_q;
        posb_d = posb_q;
        if (step_a) posa_d = fwd_a ? pos_inc(posa_q) : pos_dec(posa_q);
        if (step_b) posb_d = fwd_b ? pos_inc(posb_q) : pos_dec(posb_q);
    end

    always_comb begin
        in_siding_d = in_siding_q;
        if (step_a && fwd_a && bus.sw3 && (posa_d == POS_BRANCH)) begin
            in_siding_d = 1'b1;
        end else if (step_a && in_siding_q &&
                     ((posa_d == POS_MERGE) || (posa_d == POS_BR_M1))) begin
            in_siding_d = 1'b0;
        end
    end

    always_comb begin
        collision_d = collision_q | (in_shared(posa_q) & in_shared(posb_q));
        fault_d     = fault_q | (bus.ta0 & bus.ta1) | (bus.tb0 & bus.tb1);
        s1_d        = (posa_q == POS_S1);
        s2_d        = (posb_q == POS_S2);
        s3_d        = (posa_q == POS_S3) | (posb_q == POS_S3);
        s4_d        = ((posa_q == POS_S4) & ~in_siding_q) | (posb_q == POS_S4);
        s5_d        = (posa_q == POS_S5) & in_siding_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            posa_q      <= POS_S1;
            posb_q      <= POS_S2;
            presc_a_q   <= '0;
            presc_b_q   <= '0;
            in_siding_q <= 1'b0;
            collision_q <= 1'b0;
            fault_q     <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            s4_q        <= 1'b0;
            s5_q        <= 1'b0;
        end else begin
            posa_q      <= posa_d;
            posb_q      <= posb_d;
            presc_a_q   <= presc_a_d;
            presc_b_q   <= presc_b_d;
            in_siding_q <= in_siding_d;
            collision_q <= collision_d;
            fault_q     <= fault_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            s4_q        <= s4_d;
            s5_q        <= s5_d;
        end
    end

    assign bus.s1        = s1_q;
    assign bus.s2        = s2_q;
    assign bus.s3        = s3_q;
    assign bus.s4        = s4_q;
    assign bus.s5        = s5_q;
    assign bus.collision = collision_q;
    assign bus.fault     = fault_q;
    assign bus.posa      = posa_q;
    assign bus.posb      = posb_q;
endmodule

// File: tb/tb_train_plant_model.sv
// Directed bench for train_plant_model with STEP_DIV=4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_train_plant_model;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    train_plant_model_if #(.PW(6)) bus ();

    train_plant_model #(.STEP_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic ta0, input logic ta1, input logic tb0,
                         input logic tb1, input logic sw3);
        bus.ta0 = ta0;
        bus.ta1 = ta1;
        bus.tb0 = tb0;
        bus.tb1 = tb1;
        bus.sw3 = sw3;
    endtask

    // Leaves reset released exactly on a falling edge (called N0 below).
    task automatic apply_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int errs;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(2);
        total++;
        if ({bus.s1, bus.s2, bus.s3, bus.s4, bus.s5, bus.collision, bus.fault} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.s1, bus.s2, bus.s3, bus.s4, bus.s5, bus.collision, bus.fault});
        end
        total++;
        if (bus.posa !== 6'd0 || bus.posb !== 6'd32) begin
            bad++;
            $display("FAIL reset_pos: got posa=%0d posb=%0d want 0 32", bus.posa, bus.posb);
        end
        reset = 1'b0;
        tick(1);
        total++;
        if (bus.s1 !== 1'b1 || bus.s2 !== 1'b1) begin
            bad++;
            $display("FAIL first_edge_s1s2: got %b%b want 11", bus.s1, bus.s2);
        end
        errs = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if ({bus.s1, bus.s2, bus.s3, bus.s4, bus.s5, bus.collision, bus.fault} !== 7'b1100000 ||
                bus.posa !== 6'd0 || bus.posb !== 6'd32) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL idle_hold: got %0d bad cycles want 0", errs);
        end
    endtask

    task automatic test_forward_wrap();
        int s3_hi;
        apply_reset();
        drive(1, 0, 0, 0, 0);
        tick(4);
        total++;
        if (bus.posa !== 6'd1 || bus.s1 !== 1'b1) begin
            bad++;
            $display("FAIL fwd_first_step: got posa=%0d s1=%b want 1 1", bus.posa, bus.s1);
        end
        tick(1);
        total++;
        if (bus.s1 !== 1'b0) begin
            bad++;
            $display("FAIL fwd_s1_fall: got %b want 0", bus.s1);
        end
        tick(59);
        total++;
        if (bus.posa !== 6'd16 || bus.s3 !== 1'b0) begin
            bad++;
            $display("FAIL fwd_pos16: got posa=%0d s3=%b want 16 0", bus.posa, bus.s3);
        end
        s3_hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.s3 === 1'b1) s3_hi++;
        end
        total++;
        if (s3_hi !== 4) begin
            bad++;
            $display("FAIL fwd_s3_width: got %0d want 4", s3_hi);
        end
        tick(180);
        total++;
        if (bus.posa !== 6'd63) begin
            bad++;
            $display("FAIL fwd_pos63: got %0d want 63", bus.posa);
        end
        tick(4);
        total++;
        if (bus.posa !== 6'd0) begin
            bad++;
            $display("FAIL fwd_wrap: got %0d want 0", bus.posa);
        end
        tick(1);
        total++;
        if (bus.s1 !== 1'b1) begin
            bad++;
            $display("FAIL fwd_s1_reassert: got %b want 1", bus.s1);
        end
    endtask

    task automatic test_reverse_wrap();
        apply_reset();
        drive(0, 0, 0, 1, 0);
        tick(3);
        total++;
        if (bus.posb !== 6'd32) begin
            bad++;
            $display("FAIL rev_b_early: got %0d want 32", bus.posb);
        end
        tick(1);
        total++;
        if (bus.posb !== 6'd31) begin
            bad++;
            $display("FAIL rev_b_step: got %0d want 31", bus.posb);
        end
        apply_reset();
        drive(0, 1, 0, 0, 0);
        tick(4);
        total++;
        if (bus.posa !== 6'd63 || bus.posb !== 6'd32) begin
            bad++;
            $display("FAIL rev_a_wrap: got posa=%0d posb=%0d want 63 32", bus.posa, bus.posb);
        end
    endtask

    task automatic test_siding();
        int s5_hi;
        apply_reset();
        drive(1, 0, 0, 0, 1);
        tick(96);
        total++;
        if (bus.posa !== 6'd24 || bus.s5 !== 1'b0) begin
            bad++;
            $display("FAIL sid_pos24: got posa=%0d s5=%b want 24 0", bus.posa, bus.s5);
        end
        tick(1);
        total++;
        if (bus.s5 !== 1'b1 || bus.s4 !== 1'b0) begin
            bad++;
            $display("FAIL sid_s5_high: got s5=%b s4=%b want 1 0", bus.s5, bus.s4);
        end
        s5_hi = 1;
        for (int i = 0; i < 96; i++) begin
            tick(1);
            if (bus.s5 === 1'b1) s5_hi++;
        end
        total++;
        if (s5_hi !== 4) begin
            bad++;
            $display("FAIL sid_s5_width: got %0d want 4", s5_hi);
        end
        total++;
        if (bus.posa !== 6'd48 || bus.s4 !== 1'b1) begin
            bad++;
            $display("FAIL sid_s4_after_merge: got posa=%0d s4=%b want 48 1", bus.posa, bus.s4);
        end
        apply_reset();
        drive(1, 0, 0, 0, 0);
        s5_hi = 0;
        for (int i = 0; i < 193; i++) begin
            tick(1);
            if (bus.s5 === 1'b1) s5_hi++;
        end
        total++;
        if (s5_hi !== 0 || bus.s4 !== 1'b1) begin
            bad++;
            $display("FAIL nosid_s5: got s5_count=%0d s4=%b want 0 1", s5_hi, bus.s4);
        end
        apply_reset();
        drive(0, 1, 0, 0, 1);
        s5_hi = 0;
        for (int i = 0; i < 180; i++) begin
            tick(1);
            if (bus.s5 === 1'b1) s5_hi++;
        end
        total++;
        if (s5_hi !== 0 || bus.posa !== 6'd19) begin
            bad++;
            $display("FAIL rev_entry_sid: got s5_count=%0d posa=%0d want 0 19", s5_hi, bus.posa);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        drive(1, 0, 0, 1, 0);
        tick(48);
        total++;
        if (bus.posa !== 6'd12 || bus.posb !== 6'd20 || bus.collision !== 1'b0) begin
            bad++;
            $display("FAIL col_overlap: got posa=%0d posb=%0d col=%b want 12 20 0",
                     bus.posa, bus.posb, bus.collision);
        end
        tick(1);
        total++;
        if (bus.collision !== 1'b1) begin
            bad++;
            $display("FAIL col_set: got %b want 1", bus.collision);
        end
        tick(1000);
        total++;
        if (bus.posa !== 6'd12 || bus.posb !== 6'd20 || bus.collision !== 1'b1) begin
            bad++;
            $display("FAIL col_frozen: got posa=%0d posb=%0d col=%b want 12 20 1",
                     bus.posa, bus.posb, bus.collision);
        end
        reset = 1'b1;
        tick(1);
        total++;
        if (bus.collision !== 1'b0 || bus.posa !== 6'd0 || bus.posb !== 6'd32) begin
            bad++;
            $display("FAIL col_reset: got col=%b posa=%0d posb=%0d want 0 0 32",
                     bus.collision, bus.posa, bus.posb);
        end
        reset = 1'b0;
    endtask

    task automatic test_fault();
        apply_reset();
        drive(1, 1, 1, 0, 0);
        total++;
        if (bus.fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_pre: got %b want 0", bus.fault);
        end
        tick(1);
        total++;
        if (bus.fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_set: got %b want 1", bus.fault);
        end
        tick(7);
        total++;
        if (bus.posa !== 6'd0 || bus.posb !== 6'd34 || bus.fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_motion: got posa=%0d posb=%0d fault=%b want 0 34 1",
                     bus.posa, bus.posb, bus.fault);
        end
        tick(2);
        reset = 1'b1;
        #1;
        total++;
        if (bus.fault !== 1'b0 || bus.posa !== 6'd0 || bus.posb !== 6'd32) begin
            bad++;
            $display("FAIL fault_reset: got fault=%b posa=%0d posb=%0d want 0 0 32",
                     bus.fault, bus.posa, bus.posb);
        end
        tick(2);
        drive(0, 0, 1, 0, 0);
        reset = 1'b0;
        tick(3);
        total++;
        if (bus.posb !== 6'd32 || bus.fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_discards_count: got posb=%0d fault=%b want 32 0",
                     bus.posb, bus.fault);
        end
        tick(1);
        total++;
        if (bus.posb !== 6'd33) begin
            bad++;
            $display("FAIL post_reset_step: got %0d want 33", bus.posb);
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus.sw1 = 1'b0;
        bus.sw2 = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_forward_wrap();
        test_reverse_wrap();
        test_siding();
        test_collision();
        test_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
